// File: rtl/multiport_regfile.sv
// Multi-port register file: NR combinational read ports, NW synchronous write ports.
// A clear sweep zeroes every entry after reset and on a clr request; busy is high
// for the whole sweep. Among write ports that target the same entry, the highest
// index wins.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data to matching reads.
module multiport_regfile #(
    parameter int unsigned DW       = 32,
    parameter int unsigned DEPTH    = 34,
    parameter int unsigned AW       = 6,
    parameter int unsigned NR       = 16,
    parameter int unsigned NW       = 4,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic [NR*AW-1:0]     raddr,
    output logic [NR*DW-1:0]     rdata,
    input  logic [NW-1:0]        we,
    input  logic [NW*AW-1:0]     waddr,
    input  logic [NW*DW-1:0]     wdata,
    output logic                 busy
);

    localparam bit ZeroEn = (ZERO_REG != 0);

    typedef enum logic [0:0] {StInit, StReady} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   scnt_q, scnt_d;
    logic [DW-1:0]   mem_q [DEPTH];
    logic [NW-1:0]   wr_hit [DEPTH];

    // State and sweep counter; reset restarts the sweep at entry 0
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StInit;
            scnt_q  <= '0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
        end
    end

    // Next-state: walk every entry in INIT, accept clr only in READY
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        unique case (state_q)
            StInit: begin
                if (scnt_q == AW'(DEPTH - 1)) begin
                    state_d = StReady;
                    scnt_d  = '0;
                end else begin
                    scnt_d = scnt_q + AW'(1);
                end
            end
            StReady: begin
                if (clr) begin
                    state_d = StInit;
                    scnt_d  = '0;
                end
            end
            default: begin
                state_d = StInit;
                scnt_d  = '0;
            end
        endcase
    end

    // Qualified write hits per entry; out-of-range addresses match no entry
    always_comb begin
        for (int unsigned e = 0; e < DEPTH; e++) begin
            wr_hit[e] = '0;
            for (int unsigned j = 0; j < NW; j++) begin
                wr_hit[e][j] = we[j] && !rst && (state_q == StReady) &&
                               (waddr[j*AW +: AW] == AW'(e)) && !(ZeroEn && (e == 0));
            end
        end
    end

    // Storage update; later (higher-index) ports override earlier ones
    always_ff @(posedge clk) begin
        for (int unsigned e = 0; e < DEPTH; e++) begin
            if (!rst && (state_q == StInit) && (scnt_q == AW'(e))) begin
                mem_q[e] <= '0;
            end
            for (int unsigned j = 0; j < NW; j++) begin
                if (wr_hit[e][j]) begin
                    mem_q[e] <= wdata[j*DW +: DW];
                end
            end
        end
    end

    // Combinational reads; busy, out-of-range and zero entry force 0
    always_comb begin
        rdata = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                if ((state_q == StReady) && (raddr[i*AW +: AW] == AW'(e)) &&
                    !(ZeroEn && (e == 0))) begin
                    rdata[i*DW +: DW] = mem_q[e];
`ifdef REGFILE_BYPASS_EN
                    for (int unsigned j = 0; j < NW; j++) begin
                        if (wr_hit[e][j]) begin
                            rdata[i*DW +: DW] = wdata[j*DW +: DW];
                        end
                    end
`endif
                end
            end
        end
    end

    assign busy = (state_q == StInit);

endmodule
